// File: rtl/camo_key_pkg.sv
// rtl/camo_key_pkg.sv - shared key-loader constants and FSM state type
// Optional feature macro: CAMO_KEY_PARITY_EN (appends an even-parity bit to each key frame).
package camo_key_pkg;

    localparam int NUM_CAMO_GATES = 6;
    localparam int KEY_W          = NUM_CAMO_GATES * 2;
    localparam int CNT_W          = $clog2(KEY_W + 2);

`ifdef CAMO_KEY_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    localparam int LOAD_W = KEY_W + int'(PARITY_EN);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        CHECK  = 2'd2,
        LOADED = 2'd3
    } state_e;

endpackage

// File: rtl/camo_key_shreg.sv
// rtl/camo_key_shreg.sv - serial key shadow register with bit counter, done flag and running parity
module camo_key_shreg #(
    parameter int KEY_W = 12,
    parameter int LW    = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic          bit_in,
    output logic [LW-1:0] shadow,
    output logic          done,
    output logic          parity
);
    import camo_key_pkg::*;

    localparam int SH_CNT_W = $clog2(KEY_W + 2);

    logic [SH_CNT_W-1:0] cnt_q, cnt_d;
    logic [LW-1:0]       shadow_q, shadow_d;
    logic                done_q, done_d;
    logic                par_q, par_d;

    always_comb begin
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        done_d   = done_q;
        par_d    = par_q;
        if (clr) begin
            cnt_d    = '0;
            shadow_d = '0;
            done_d   = 1'b0;
            par_d    = 1'b0;
        end else if (en && !done_q) begin
            // Shadow is cleared at start, so OR-ing each bit into place is a write
            shadow_d = shadow_q | (LW'(bit_in) << cnt_q);
            par_d    = par_q ^ bit_in;
            cnt_d    = cnt_q + SH_CNT_W'(1);
            done_d   = (cnt_q == SH_CNT_W'(LW - 1));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            shadow_q <= '0;
            done_q   <= 1'b0;
            par_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            done_q   <= done_d;
            par_q    <= par_d;
        end
    end

    assign shadow = shadow_q;
    assign done   = done_q;
    assign parity = par_q;

endmodule

// File: rtl/camo_key_loader.sv
// rtl/camo_key_loader.sv - camouflage key loader: FSM, commit register and sticky write-protect
// Optional feature macro: CAMO_KEY_PARITY_EN (even-parity check on each loaded frame).
module camo_key_loader #(
    parameter int KEY_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_start,
    input  logic             key_sin,
    input  logic             key_sin_vld,
    input  logic             key_lock,
    output logic [KEY_W-1:0] key_out,
    output logic             key_valid,
    output logic             key_busy,
    output logic             key_err,
    output logic             key_locked
);
    import camo_key_pkg::*;

    localparam int LOAD_LEN = KEY_W + int'(PARITY_EN);

    state_e           state_q, state_d;
    logic [KEY_W-1:0] key_out_q, key_out_d;
    logic             key_valid_q, key_valid_d;
    logic             key_busy_q, key_busy_d;
    logic             key_err_q, key_err_d;
    logic             key_locked_q, key_locked_d;

    logic                sh_clr;
    logic                sh_en;
    logic [LOAD_LEN-1:0] sh_shadow;
    logic                sh_done;
    logic                sh_parity;
    logic                start_ok;
    logic                check_ok;

    camo_key_shreg #(
        .KEY_W (KEY_W),
        .LW    (LOAD_LEN)
    ) u_shreg (
        .clk    (clk),
        .rst    (rst),
        .clr    (sh_clr),
        .en     (sh_en),
        .bit_in (key_sin),
        .shadow (sh_shadow),
        .done   (sh_done),
        .parity (sh_parity)
    );

    // Lock beats a simultaneous start in LOADED; once locked, starts are dead until reset
    assign start_ok = key_start && !key_locked_q && !(state_q == LOADED && key_lock);
    assign check_ok = !(PARITY_EN && sh_parity);

    always_comb begin
        state_d      = state_q;
        key_out_d    = key_out_q;
        key_valid_d  = key_valid_q;
        key_err_d    = key_err_q;
        key_locked_d = key_locked_q;
        sh_clr       = 1'b0;
        sh_en        = 1'b0;
        case (state_q)
            IDLE, LOADED: begin
                if (state_q == LOADED && key_lock) begin
                    key_locked_d = 1'b1;
                end
                if (start_ok) begin
                    state_d     = SHIFT;
                    sh_clr      = 1'b1;
                    key_err_d   = 1'b0;
                    key_valid_d = 1'b0;
                end
            end
            SHIFT: begin
                if (key_start) begin
                    sh_clr = 1'b1;
                end else if (sh_done) begin
                    state_d = CHECK;
                end else begin
                    sh_en = key_sin_vld;
                end
            end
            CHECK: begin
                if (check_ok) begin
                    key_out_d   = sh_shadow[KEY_W-1:0];
                    key_valid_d = 1'b1;
                    state_d     = LOADED;
                end else begin
                    key_err_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        key_busy_d = (state_d == SHIFT) || (state_d == CHECK);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            key_out_q    <= '0;
            key_valid_q  <= 1'b0;
            key_busy_q   <= 1'b0;
            key_err_q    <= 1'b0;
            key_locked_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            key_out_q    <= key_out_d;
            key_valid_q  <= key_valid_d;
            key_busy_q   <= key_busy_d;
            key_err_q    <= key_err_d;
            key_locked_q <= key_locked_d;
        end
    end

    assign key_out    = key_out_q;
    assign key_valid  = key_valid_q;
    assign key_busy   = key_busy_q;
    assign key_err    = key_err_q;
    assign key_locked = key_locked_q;

endmodule

// File: tb/tb_camo_key_loader.sv
// tb/tb_camo_key_loader.sv - randomized self-checking bench for camo_key_loader against a transaction-level model
module tb_camo_key_loader;

    localparam int KEY_W = 12;
`ifdef CAMO_KEY_PARITY_EN
    localparam int LOAD_W = KEY_W + 1;
`else
    localparam int LOAD_W = KEY_W;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             key_start;
    logic             key_sin;
    logic             key_sin_vld;
    logic             key_lock;
    logic [KEY_W-1:0] key_out;
    logic             key_valid;
    logic             key_busy;
    logic             key_err;
    logic             key_locked;

    int n_checks = 0;
    int n_fail   = 0;

    logic [KEY_W-1:0] m_key;
    bit               m_valid, m_err, m_locked, m_loaded;

    camo_key_loader #(.KEY_W(KEY_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .key_start   (key_start),
        .key_sin     (key_sin),
        .key_sin_vld (key_sin_vld),
        .key_lock    (key_lock),
        .key_out     (key_out),
        .key_valid   (key_valid),
        .key_busy    (key_busy),
        .key_err     (key_err),
        .key_locked  (key_locked)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(input string tag, input bit busy);
        check_eq({tag, ".key_out"},    32'(key_out),    32'(m_key));
        check_eq({tag, ".key_valid"},  32'(key_valid),  32'(m_valid));
        check_eq({tag, ".key_err"},    32'(key_err),    32'(m_err));
        check_eq({tag, ".key_locked"}, 32'(key_locked), 32'(m_locked));
        check_eq({tag, ".key_busy"},   32'(key_busy),   32'(busy));
    endtask

    function automatic logic [LOAD_W-1:0] make_frame(input logic [KEY_W-1:0] k, input bit corrupt);
        logic [LOAD_W-1:0] f;
`ifdef CAMO_KEY_PARITY_EN
        f = {(^k) ^ corrupt, k};
`else
        f = k;
        if (corrupt) f = k;
`endif
        return f;
    endfunction

    function automatic bit frame_ok(input logic [LOAD_W-1:0] f);
`ifdef CAMO_KEY_PARITY_EN
        return (^f) == 1'b0;
`else
        return (f == f);
`endif
    endfunction

    task automatic model_reset;
        m_key = '0; m_valid = 0; m_err = 0; m_locked = 0; m_loaded = 0;
    endtask

    // Full load transaction: optional garbage prefix + restart, optional gaps, then latency and commit checks
    task automatic load_frame(input logic [LOAD_W-1:0] f, input int gap_at, input int gap_len,
                              input int max_gap, input int restart_at);
        int gap;
        key_start = 1'b1; tick; key_start = 1'b0;
        if (m_locked) begin
            check_outputs("locked_start", 1'b0);
            return;
        end
        m_valid = 0; m_err = 0; m_loaded = 0;
        check_outputs("shift_entry", 1'b1);
        if (restart_at > 0) begin
            for (int i = 0; i < restart_at; i++) begin
                key_sin = 1'($urandom); key_sin_vld = 1'b1; tick;
            end
            key_start = 1'b1; key_sin = 1'b1; tick;
            key_start = 1'b0; key_sin_vld = 1'b0;
            check_eq("restart_busy", 32'(key_busy), 32'd1);
        end
        for (int i = 0; i < LOAD_W; i++) begin
            gap = (i == gap_at) ? gap_len : ((max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
            repeat (gap) begin
                key_sin_vld = 1'b0; key_sin = 1'($urandom); tick;
                check_eq("gap_busy", 32'(key_busy), 32'd1);
            end
            key_sin = f[i]; key_sin_vld = 1'b1; tick;
            check_eq("hold_key_out", 32'(key_out), 32'(m_key));
        end
        key_sin_vld = 1'b0;
        tick;
        check_eq("lat1_key_out", 32'(key_out),   32'(m_key));
        check_eq("lat1_valid",   32'(key_valid), 32'd0);
        check_eq("lat1_busy",    32'(key_busy),  32'd1);
        tick;
        if (frame_ok(f)) begin
            m_key = f[KEY_W-1:0]; m_valid = 1; m_loaded = 1;
        end else begin
            m_err = 1;
        end
        check_outputs("commit", 1'b0);
    endtask

    task automatic try_lock(input bit with_start);
        key_lock = 1'b1; key_start = with_start; tick;
        key_lock = 1'b0; key_start = 1'b0;
        if (m_loaded) m_locked = 1;
        check_outputs("lock", 1'b0);
    endtask

    task automatic async_reset_mid_load(input logic [LOAD_W-1:0] f, input int bitn);
        key_start = 1'b1; tick; key_start = 1'b0;
        for (int i = 0; i < bitn; i++) begin
            key_sin = f[i]; key_sin_vld = 1'b1; tick;
        end
        key_sin = f[bitn]; key_sin_vld = 1'b1;
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_outputs("async_rst", 1'b0);
        key_sin_vld = 1'b0;
        tick;
        #2 rst = 1'b0;
        tick; tick;
        check_outputs("post_rst", 1'b0);
    endtask

    initial begin
        rst = 1'b1; key_start = 1'b0; key_sin = 1'b0; key_sin_vld = 1'b0; key_lock = 1'b0;
        model_reset();
        #1;
        check_outputs("reset", 1'b0);
        tick;
        #2 rst = 1'b0;
        tick;
        check_outputs("idle", 1'b0);

        load_frame(make_frame(12'hA5C, 0), -1, 0, 0, 0);
        check_eq("direct_a5c", 32'(key_out), 32'h0A5C);
        load_frame(make_frame(12'hA5C, 0), 6, 5, 0, 0);
        load_frame(make_frame(12'h3F0, 0), -1, 0, 0, 0);
        check_eq("direct_3f0", 32'(key_out), 32'h03F0);

`ifdef CAMO_KEY_PARITY_EN
        load_frame(13'h1001, -1, 0, 0, 0);
        check_eq("par_good_key", 32'(key_out), 32'h001);
        load_frame(13'h0001, -1, 0, 0, 0);
        check_eq("par_bad_err", 32'(key_err), 32'd1);
        check_eq("par_bad_key", 32'(key_out), 32'h001);
`endif

        load_frame(make_frame(12'h3F0, 0), -1, 0, 0, 5);
        load_frame(make_frame(12'hA5C, 0), -1, 0, 0, 0);
        try_lock(1'b1);
        check_eq("lock_set", 32'(key_locked), 32'd1);
        load_frame(make_frame(12'h123, 0), -1, 0, 0, 0);
        rst = 1'b1; #1;
        model_reset();
        check_outputs("lock_rst", 1'b0);
        tick; #2 rst = 1'b0; tick;

        load_frame(make_frame(12'h5A5, 0), -1, 0, 0, 0);
        async_reset_mid_load(make_frame(12'h7E5, 0), 7);

        for (int it = 0; it < 40; it++) begin
            int op;
            op = int'($urandom_range(0, 9));
            if (op <= 5) begin
                int rs;
                rs = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, LOAD_W - 1)) : 0;
                load_frame(make_frame(12'($urandom), ($urandom_range(0, 3) == 0)), -1, 0, 2, rs);
            end else if (op <= 7) begin
                try_lock(m_loaded ? 1'($urandom) : 1'b0);
            end else if (op == 8) begin
                try_lock(1'b0);
            end else begin
                async_reset_mid_load(make_frame(12'($urandom), 0), int'($urandom_range(0, LOAD_W - 1)));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
